// File: rtl/bloom_lookup_arbiter_if.sv
// ----------------------------------------------------------------------------
// bloom_lookup_arbiter_if
//
// Purpose:
//   Bundles every bus of the bloom-filter lookup arbiter into one interface.
//   The bundle covers the requester handshake, the engine lookup/result path
//   and the bit-array configuration path.
//
// Parameters:
//   NREQ  number of requesters
//   KEYW  key width
//   IDXW  bit-array index width
//
// Signals (direction as seen by the arbiter, modport slave):
//   req_valid    in   NREQ       requester i presents a key
//   req_key      in   NREQ*KEYW  key i at [i*KEYW +: KEYW]
//   req_ready    out  NREQ       one-hot accept pulse
//   res_valid    out  NREQ       one-hot result pulse
//   res_hit      out  1          lookup result (1 = possibly present)
//   res_timeout  out  1          result was forced by the response timeout
//   bf_valid     out  1          lookup request to the engine
//   bf_key       out  KEYW       latched key to the engine
//   bf_ready     in   1          engine accepts the request
//   bf_res_valid in   1          engine result strobe
//   bf_res_hit   in   1          engine result
//   cfg_wr_en    in   1          config write request
//   cfg_wr_idx   in   IDXW       bit index to write
//   cfg_wr_data  in   1          bit value
//   cfg_busy     out  1          config write not accepted this cycle
//   bf_cfg_we    out  1          write strobe to the engine bit array
//   bf_cfg_idx   out  IDXW       write index
//   bf_cfg_data  out  1          write value
//
// Modports:
//   slave   the arbiter
//   master  the surrounding requesters, engine and config source
// ----------------------------------------------------------------------------
interface bloom_lookup_arbiter_if #(
    parameter int NREQ = 4,
    parameter int KEYW = 104,
    parameter int IDXW = 3
);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ*KEYW-1:0] req_key;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      res_valid;
    logic                 res_hit;
    logic                 res_timeout;

    logic                 bf_valid;
    logic [KEYW-1:0]      bf_key;
    logic                 bf_ready;
    logic                 bf_res_valid;
    logic                 bf_res_hit;

    logic                 cfg_wr_en;
    logic [IDXW-1:0]      cfg_wr_idx;
    logic                 cfg_wr_data;
    logic                 cfg_busy;
    logic                 bf_cfg_we;
    logic [IDXW-1:0]      bf_cfg_idx;
    logic                 bf_cfg_data;

    modport slave (
        input  req_valid, req_key, bf_ready, bf_res_valid, bf_res_hit,
               cfg_wr_en, cfg_wr_idx, cfg_wr_data,
        output req_ready, res_valid, res_hit, res_timeout, bf_valid, bf_key,
               cfg_busy, bf_cfg_we, bf_cfg_idx, bf_cfg_data
    );

    modport master (
        output req_valid, req_key, bf_ready, bf_res_valid, bf_res_hit,
               cfg_wr_en, cfg_wr_idx, cfg_wr_data,
        input  req_ready, res_valid, res_hit, res_timeout, bf_valid, bf_key,
               cfg_busy, bf_cfg_we, bf_cfg_idx, bf_cfg_data
    );

endinterface

// File: rtl/bloom_lookup_arbiter.sv
// ----------------------------------------------------------------------------
// bloom_lookup_arbiter
//
// Purpose:
//   Shares one bloom-filter lookup engine among NREQ packet-classifier
//   requesters. Requesters are served round-robin with a single lookup in
//   flight; the result is routed back to the granted requester. Bit-array
//   configuration writes are slipped into the engine whenever no lookup is
//   in flight, and a response timeout forces a miss so the arbiter can
//   never hang on a silent engine.
//
// Parameters:
//   NREQ     number of requesters (2..8)
//   KEYW     key width
//   IDXW     bit-array index width
//   TIMEOUT  WAIT_RESP cycles before a forced miss (>= 2)
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   bus    bloom_lookup_arbiter_if.slave (requester, engine and config buses)
//   stat_lookups / stat_hits / stat_timeouts
//          32-bit saturating counters, present only with the optional build
//
// Optional build:
//   Define BLOOM_ARB_STATS_EN to add the statistics counters and ports.
// ----------------------------------------------------------------------------
module bloom_lookup_arbiter #(
    parameter int NREQ    = 4,
    parameter int KEYW    = 104,
    parameter int IDXW    = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef BLOOM_ARB_STATS_EN
    output logic [31:0]           stat_lookups,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_timeouts,
`endif
    bloom_lookup_arbiter_if.slave bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PLAST = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP,
        DELIVER
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rrPtr_q, rrPtr_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [KEYW-1:0] key_q, key_d;
    logic            hit_q, hit_d;
    logic            tout_q, tout_d;
    logic            cfgWe_q, cfgWe_d;
    logic [IDXW-1:0] cfgIdx_q, cfgIdx_d;
    logic            cfgData_q, cfgData_d;

    logic            anyReq;
    logic [PW-1:0]   pick;

    logic [NREQ-1:0] reqReady;
    logic [NREQ-1:0] resValid;
    logic            resHit;
    logic            resTimeout;
    logic            bfValid;
    logic            cfgBusy;

    // Round-robin search: scan the requesters starting at the pointer and
    // wrapping past NREQ-1, so the first valid one found is the requester
    // that has waited longest since its last service.
    always_comb begin
        anyReq = 1'b0;
        pick   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!anyReq && bus.req_valid[(int'(rrPtr_q) + k) % NREQ]) begin
                anyReq = 1'b1;
                pick   = PW'((int'(rrPtr_q) + k) % NREQ);
            end
        end
    end

    // Next-state and output decode. Config writes win over lookups in IDLE
    // so that table updates are never starved by heavy traffic. The engine
    // result is only looked at in WAIT_RESP, so stray strobes elsewhere are
    // harmless, and a real result beats the timeout when both coincide.
    // Reset forces every output low except cfg_busy, which stays high so the
    // config source holds its write until the arbiter is usable again.
    always_comb begin
        state_d    = state_q;
        rrPtr_d    = rrPtr_q;
        gnt_d      = gnt_q;
        timer_d    = timer_q;
        key_d      = key_q;
        hit_d      = hit_q;
        tout_d     = tout_q;
        cfgWe_d    = 1'b0;
        cfgIdx_d   = cfgIdx_q;
        cfgData_d  = cfgData_q;
        reqReady   = '0;
        resValid   = '0;
        resHit     = 1'b0;
        resTimeout = 1'b0;
        bfValid    = 1'b0;
        cfgBusy    = 1'b1;

        unique case (state_q)
            IDLE: begin
                cfgBusy = 1'b0;
                if (bus.cfg_wr_en) begin
                    cfgWe_d   = 1'b1;
                    cfgIdx_d  = bus.cfg_wr_idx;
                    cfgData_d = bus.cfg_wr_data;
                end else if (anyReq) begin
                    reqReady[pick] = 1'b1;
                    key_d          = bus.req_key[int'(pick)*KEYW +: KEYW];
                    gnt_d          = pick;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                bfValid = 1'b1;
                if (bus.bf_ready) begin
                    timer_d = '0;
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                timer_d = timer_q + 1'b1;
                if (bus.bf_res_valid) begin
                    hit_d   = bus.bf_res_hit;
                    tout_d  = 1'b0;
                    state_d = DELIVER;
                end else if (timer_q == TLAST) begin
                    hit_d   = 1'b0;
                    tout_d  = 1'b1;
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                resValid[gnt_q] = 1'b1;
                resHit          = hit_q;
                resTimeout      = tout_q;
                rrPtr_d         = (gnt_q == PLAST) ? '0 : gnt_q + 1'b1;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reset) begin
            reqReady   = '0;
            resValid   = '0;
            resHit     = 1'b0;
            resTimeout = 1'b0;
            bfValid    = 1'b0;
            cfgBusy    = 1'b1;
        end
    end

    // State register. Reset abandons any lookup in flight and restarts the
    // round-robin pointer at requester 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rrPtr_q   <= '0;
            gnt_q     <= '0;
            timer_q   <= '0;
            key_q     <= '0;
            hit_q     <= 1'b0;
            tout_q    <= 1'b0;
            cfgWe_q   <= 1'b0;
            cfgIdx_q  <= '0;
            cfgData_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rrPtr_q   <= rrPtr_d;
            gnt_q     <= gnt_d;
            timer_q   <= timer_d;
            key_q     <= key_d;
            hit_q     <= hit_d;
            tout_q    <= tout_d;
            cfgWe_q   <= cfgWe_d;
            cfgIdx_q  <= cfgIdx_d;
            cfgData_q <= cfgData_d;
        end
    end

    assign bus.req_ready   = reqReady;
    assign bus.res_valid   = resValid;
    assign bus.res_hit     = resHit;
    assign bus.res_timeout = resTimeout;
    assign bus.bf_valid    = bfValid;
    assign bus.cfg_busy    = cfgBusy;
    assign bus.bf_key      = reset ? '0 : key_q;
    assign bus.bf_cfg_we   = reset ? 1'b0 : cfgWe_q;
    assign bus.bf_cfg_idx  = reset ? '0 : cfgIdx_q;
    assign bus.bf_cfg_data = reset ? 1'b0 : cfgData_q;

`ifdef BLOOM_ARB_STATS_EN
    logic [31:0] statLookups_q, statLookups_d;
    logic [31:0] statHits_q, statHits_d;
    logic [31:0] statTimeouts_q, statTimeouts_d;

    // Statistics advance once per delivered result and stick at all-ones
    // instead of wrapping, so a long run never reports a misleading count.
    always_comb begin
        statLookups_d  = statLookups_q;
        statHits_d     = statHits_q;
        statTimeouts_d = statTimeouts_q;
        if (state_q == DELIVER) begin
            if (statLookups_q != '1) begin
                statLookups_d = statLookups_q + 1'b1;
            end
            if (hit_q && statHits_q != '1) begin
                statHits_d = statHits_q + 1'b1;
            end
            if (tout_q && statTimeouts_q != '1) begin
                statTimeouts_d = statTimeouts_q + 1'b1;
            end
        end
    end

    // Statistics registers, cleared together with the rest of the arbiter.
    always_ff @(posedge clk) begin
        if (reset) begin
            statLookups_q  <= '0;
            statHits_q     <= '0;
            statTimeouts_q <= '0;
        end else begin
            statLookups_q  <= statLookups_d;
            statHits_q     <= statHits_d;
            statTimeouts_q <= statTimeouts_d;
        end
    end

    assign stat_lookups  = reset ? '0 : statLookups_q;
    assign stat_hits     = reset ? '0 : statHits_q;
    assign stat_timeouts = reset ? '0 : statTimeouts_q;
`endif

endmodule

// File: tb/tb_bloom_lookup_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bloom_lookup_arbiter
//
// Purpose:
//   Self-checking bench for bloom_lookup_arbiter. The bench plays requesters,
//   engine and config source through the interface. A transaction-level model
//   predicts each grant from a round-robin pointer and each result from the
//   engine behaviour chosen for that lookup.
//
// Optional build:
//   With BLOOM_ARB_STATS_EN defined the statistics ports are connected and
//   compared against the model's own counts.
// ----------------------------------------------------------------------------
module tb_bloom_lookup_arbiter;

    localparam int NREQ    = 4;
    localparam int KEYW    = 104;
    localparam int IDXW    = 3;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bloom_lookup_arbiter_if #(.NREQ(NREQ), .KEYW(KEYW), .IDXW(IDXW)) bus ();

`ifdef BLOOM_ARB_STATS_EN
    logic [31:0] statLookups;
    logic [31:0] statHits;
    logic [31:0] statTimeouts;
`endif

    bloom_lookup_arbiter #(
        .NREQ(NREQ), .KEYW(KEYW), .IDXW(IDXW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef BLOOM_ARB_STATS_EN
        .stat_lookups (statLookups),
        .stat_hits    (statHits),
        .stat_timeouts(statTimeouts),
`endif
        .bus          (bus)
    );

    int checks = 0;
    int errors = 0;

    int              modelPtr = 0;
    int              modelLookups = 0;
    int              modelHits = 0;
    int              modelTimeouts = 0;
    logic [KEYW-1:0] keyArr [NREQ];
    logic [IDXW-1:0] pendIdx = '0;
    logic            pendData = 1'b0;

    // One comparison: counted, and reported when the observed value differs.
    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive every scalar/vector input of the arbiter for the current cycle.
    task automatic applyStimulus(input logic [NREQ-1:0] rv, input logic br, input logic brv,
                                 input logic brh, input logic cwe, input logic [IDXW-1:0] cidx,
                                 input logic cdata);
        bus.req_valid    = rv;
        bus.bf_ready     = br;
        bus.bf_res_valid = brv;
        bus.bf_res_hit   = brh;
        bus.cfg_wr_en    = cwe;
        bus.cfg_wr_idx   = cidx;
        bus.cfg_wr_data  = cdata;
    endtask

    // Fresh random keys for all requesters, remembered by the model.
    task automatic randomizeKeys();
        for (int r = 0; r < NREQ; r++) begin
            keyArr[r] = KEYW'({$urandom, $urandom, $urandom, $urandom});
            bus.req_key[r*KEYW +: KEYW] = keyArr[r];
        end
    endtask

    // Requester that round-robin fairness says should win next.
    function automatic int expGrant(input logic [NREQ-1:0] mask);
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(modelPtr + k) % NREQ]) return (modelPtr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int g);
        logic [NREQ-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    // One full lookup starting from IDLE. respDelay counts WAIT_RESP cycles
    // before the engine answers; a value >= TIMEOUT means it never answers.
    // cfgExp: a config write strobe is due in the grant cycle.
    // cfgInWait: a config write is raised during WAIT_RESP and held.
    task automatic doLookup(input logic [NREQ-1:0] mask, input int readyDelay, input int respDelay,
                            input logic hitVal, input logic cfgExp, input logic cfgInWait);
        int   g;
        int   nWait;
        logic expTout;
        logic expHit;
        g       = expGrant(mask);
        expTout = (respDelay >= TIMEOUT);
        expHit  = expTout ? 1'b0 : hitVal;
        nWait   = expTout ? TIMEOUT : respDelay + 1;

        @(negedge clk);
        randomizeKeys();
        applyStimulus(mask, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        checkOutput("grant_ready", bus.req_ready, onehot(g));
        checkOutput("grant_cfg_busy", bus.cfg_busy, 1'b0);
        checkOutput("grant_cfg_we", bus.bf_cfg_we, cfgExp);
        if (cfgExp) begin
            checkOutput("grant_cfg_idx", bus.bf_cfg_idx, pendIdx);
            checkOutput("grant_cfg_data", bus.bf_cfg_data, pendData);
        end

        for (int c = 0; c <= readyDelay; c++) begin
            @(negedge clk);
            for (int r = 0; r < NREQ; r++) bus.req_key[r*KEYW +: KEYW] = ~keyArr[r];
            applyStimulus(mask, (c == readyDelay), 1'($urandom), 1'($urandom), 1'b0, '0, 1'b0);
            #1;
            checkOutput("issue_bf_valid", bus.bf_valid, 1'b1);
            checkOutput("issue_bf_key", bus.bf_key, keyArr[g]);
            checkOutput("issue_req_ready", bus.req_ready, '0);
            checkOutput("issue_res_valid", bus.res_valid, '0);
            checkOutput("issue_cfg_busy", bus.cfg_busy, 1'b1);
        end

        for (int w = 0; w < nWait; w++) begin
            @(negedge clk);
            applyStimulus(mask, 1'b0, (w == respDelay), (w == respDelay) ? hitVal : 1'($urandom),
                          cfgInWait, cfgInWait ? pendIdx : '0, cfgInWait ? pendData : 1'b0);
            #1;
            checkOutput("wait_bf_valid", bus.bf_valid, 1'b0);
            checkOutput("wait_res_valid", bus.res_valid, '0);
            checkOutput("wait_cfg_busy", bus.cfg_busy, 1'b1);
            checkOutput("wait_cfg_we", bus.bf_cfg_we, 1'b0);
        end

        @(negedge clk);
        applyStimulus(mask, 1'b0, 1'($urandom), 1'($urandom),
                      cfgInWait, cfgInWait ? pendIdx : '0, cfgInWait ? pendData : 1'b0);
        #1;
        checkOutput("deliver_res_valid", bus.res_valid, onehot(g));
        checkOutput("deliver_res_hit", bus.res_hit, expHit);
        checkOutput("deliver_res_timeout", bus.res_timeout, expTout);
        checkOutput("deliver_cfg_busy", bus.cfg_busy, 1'b1);

        modelPtr = (g + 1) % NREQ;
        modelLookups++;
        if (expHit) modelHits++;
        if (expTout) modelTimeouts++;
    endtask

    // All outputs low, cfg_busy high: the state expected while reset is held.
    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, bus.req_ready, '0);
        checkOutput({tag, "_res_valid"}, bus.res_valid, '0);
        checkOutput({tag, "_res_hit"}, bus.res_hit, 1'b0);
        checkOutput({tag, "_res_timeout"}, bus.res_timeout, 1'b0);
        checkOutput({tag, "_bf_valid"}, bus.bf_valid, 1'b0);
        checkOutput({tag, "_bf_key"}, bus.bf_key, '0);
        checkOutput({tag, "_bf_cfg_we"}, bus.bf_cfg_we, 1'b0);
        checkOutput({tag, "_cfg_busy"}, bus.cfg_busy, 1'b1);
    endtask

    initial begin
        logic [NREQ-1:0] m;
        int              rd;
        int              rsp;
        logic            h;

        reset = 1'b1;
        bus.req_key = '0;
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("[TB] reset state");
        checkResetOutputs("reset");
        reset = 1'b0;

        $display("[TB] continuous requests from all four");
        for (int i = 0; i < 5; i++) doLookup(4'b1111, 0, 0, 1'b0, 1'b0, 1'b0);

        $display("[TB] single requester with immediate hit");
        doLookup(4'b0010, 0, 0, 1'b1, 1'b0, 1'b0);

        $display("[TB] response timeout and its boundary");
        doLookup(4'b0100, 0, TIMEOUT + 10, 1'b1, 1'b0, 1'b0);
        doLookup(4'b0100, 2, TIMEOUT - 1, 1'b1, 1'b0, 1'b0);
        doLookup(4'b1001, 1, TIMEOUT - 2, 1'b1, 1'b0, 1'b0);

        $display("[TB] config write takes priority in IDLE");
        pendIdx  = 3'd5;
        pendData = 1'b1;
        @(negedge clk);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, pendIdx, pendData);
        #1;
        checkOutput("cfgprio_busy", bus.cfg_busy, 1'b0);
        checkOutput("cfgprio_req_ready", bus.req_ready, '0);
        checkOutput("cfgprio_cfg_we", bus.bf_cfg_we, 1'b0);
        doLookup(4'b0001, 1, 2, 1'b1, 1'b1, 1'b0);

        $display("[TB] config write held off during a lookup");
        pendIdx  = IDXW'($urandom);
        pendData = 1'($urandom);
        doLookup(4'b1000, 0, 3, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b1, pendIdx, pendData);
        #1;
        checkOutput("cfgwait_busy_idle", bus.cfg_busy, 1'b0);
        checkOutput("cfgwait_no_strobe_yet", bus.bf_cfg_we, 1'b0);
        @(negedge clk);
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        checkOutput("cfgwait_strobe", bus.bf_cfg_we, 1'b1);
        checkOutput("cfgwait_idx", bus.bf_cfg_idx, pendIdx);
        checkOutput("cfgwait_data", bus.bf_cfg_data, pendData);
        @(negedge clk);
        #1;
        checkOutput("cfgwait_single_strobe", bus.bf_cfg_we, 1'b0);

        $display("[TB] randomized lookups");
        for (int i = 0; i < 30; i++) begin
            m   = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            rd  = $urandom_range(0, 3);
            rsp = ($urandom_range(0, 4) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 1)
                                              : $urandom_range(0, 5);
            h   = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                applyStimulus('0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, '0, 1'b0);
                #1;
                checkOutput("idle_no_grant", bus.req_ready, '0);
                checkOutput("idle_no_result", bus.res_valid, '0);
                checkOutput("idle_cfg_busy", bus.cfg_busy, 1'b0);
            end
            doLookup(m, rd, rsp, h, 1'b0, 1'b0);
        end

        $display("[TB] reset during WAIT_RESP");
        doLookup(4'b0001, 0, 0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        checkOutput("abandon_grant", bus.req_ready, onehot(expGrant(4'b0110)));
        @(negedge clk);
        applyStimulus('0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        checkOutput("abandon_issue", bus.bf_valid, 1'b1);
        @(negedge clk);
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        checkOutput("abandon_wait_res", bus.res_valid, '0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus('0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        #1;
        checkResetOutputs("midreset");
        @(negedge clk);
        reset = 1'b0;
        applyStimulus('0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        #1;
        checkOutput("postreset_res_valid", bus.res_valid, '0);
        checkOutput("postreset_idle", bus.cfg_busy, 1'b0);
        @(negedge clk);
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        checkOutput("postreset_stray_ignored", bus.res_valid, '0);
        checkOutput("postreset_still_idle", bus.cfg_busy, 1'b0);
        modelPtr      = 0;
        modelLookups  = 0;
        modelHits     = 0;
        modelTimeouts = 0;
        doLookup(4'b1111, 0, 1, 1'b1, 1'b0, 1'b0);
        doLookup(4'b1111, 0, 0, 1'b0, 1'b0, 1'b0);

`ifdef BLOOM_ARB_STATS_EN
        @(negedge clk);
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        checkOutput("stat_lookups", statLookups, modelLookups);
        checkOutput("stat_hits", statHits, modelHits);
        checkOutput("stat_timeouts", statTimeouts, modelTimeouts);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
